// File: rtl/pid_ctrl.sv
// pid_ctrl: saturated PID term computation and differential wheel-speed mix.
// Three-state sequencer: IDLE captures a sample, CALC forms the PID sum, and OUT
// registers clamped left/right speeds and pulses pid_vld.
module pid_ctrl #(
  parameter int unsigned P_COEF = 3,
  parameter int unsigned D_COEF = 7,
  parameter int unsigned I_SHFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic signed [15:0] error,
  input  logic               err_vld,
  input  logic [10:0]        mast_spd,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rht_spd,
  output logic               pid_vld
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  localparam logic signed [13:0] P_K = 14'(P_COEF);
  localparam logic signed [13:0] D_K = 14'(D_COEF);

  state_e             state_q;
  logic signed [9:0]  err_sat_q, err_sat_d;
  logic signed [9:0]  prev_err_q;
  logic signed [15:0] integ_q, integ_d;
  logic signed [7:0]  d_sat_q, d_sat_d;
  logic signed [13:0] pid_q, pid_d;
  logic [10:0]        lft_spd_q, lft_spd_d;
  logic [10:0]        rht_spd_q, rht_spd_d;
  logic               pid_vld_q;

  logic signed [15:0] es16, integ_sum;
  logic signed [10:0] d_diff;
  logic signed [13:0] p_term, i_term, d_term;
  logic signed [13:0] base, lft_raw, rht_raw;

  // Capture: saturate error, update integrator (hold on overflow), clamp delta.
  always_comb begin
    err_sat_d = error[9:0];
    if (error > 16'sd511)       err_sat_d = 10'sd511;
    else if (error < -16'sd512) err_sat_d = -10'sd512;

    es16      = {{6{err_sat_d[9]}}, err_sat_d};
    integ_sum = integ_q + es16;
    integ_d   = integ_sum;
    if ((integ_q[15] == es16[15]) && (integ_sum[15] != integ_q[15]))
      integ_d = integ_q;

    // History is the previously captured sample, never the one being captured.
    d_diff  = {err_sat_d[9], err_sat_d} - {prev_err_q[9], prev_err_q};
    d_sat_d = d_diff[7:0];
    if (d_diff > 11'sd127)       d_sat_d = 8'sd127;
    else if (d_diff < -11'sd128) d_sat_d = -8'sd128;
  end

  // Term compute: P + I + D from the captured sample and the updated integrator.
  always_comb begin
    p_term = {{4{err_sat_q[9]}}, err_sat_q} * P_K;
    i_term = 14'(integ_q >>> I_SHFT);
    d_term = {{6{d_sat_q[7]}}, d_sat_q} * D_K;
    pid_d  = p_term + i_term + d_term;
  end

  // Output mix: base speed plus/minus PID, each clamped to [0,2047].
  always_comb begin
    base    = {3'b000, mast_spd};
    lft_raw = base + pid_q;
    rht_raw = base - pid_q;

    lft_spd_d = lft_raw[10:0];
    if (lft_raw < 14'sd0)         lft_spd_d = 11'd0;
    else if (lft_raw > 14'sd2047) lft_spd_d = 11'd2047;

    rht_spd_d = rht_raw[10:0];
    if (rht_raw < 14'sd0)         rht_spd_d = 11'd0;
    else if (rht_raw > 14'sd2047) rht_spd_d = 11'd2047;
  end

  // Sequencer and all datapath state; go low stops the motors and flushes history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_sat_q  <= '0;
      prev_err_q <= '0;
      integ_q    <= '0;
      d_sat_q    <= '0;
      pid_q      <= '0;
      lft_spd_q  <= '0;
      rht_spd_q  <= '0;
      pid_vld_q  <= 1'b0;
    end else if (!go) begin
      state_q    <= IDLE;
      err_sat_q  <= '0;
      prev_err_q <= '0;
      integ_q    <= '0;
      d_sat_q    <= '0;
      pid_q      <= '0;
      lft_spd_q  <= '0;
      rht_spd_q  <= '0;
      pid_vld_q  <= 1'b0;
    end else begin
      pid_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (err_vld) begin
            err_sat_q  <= err_sat_d;
            prev_err_q <= err_sat_d;
            integ_q    <= integ_d;
            d_sat_q    <= d_sat_d;
            state_q    <= CALC;
          end
        end
        CALC: begin
          pid_q   <= pid_d;
          state_q <= OUT;
        end
        OUT: begin
          lft_spd_q <= lft_spd_d;
          rht_spd_q <= rht_spd_d;
          pid_vld_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lft_spd = lft_spd_q;
  assign rht_spd = rht_spd_q;
  assign pid_vld = pid_vld_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// tb_pid_ctrl: directed plus randomized checks of pid_ctrl against an
// integer-arithmetic model of the PID rules.
module tb_pid_ctrl;

  logic               clk = 1'b0;
  logic               rst_n, go, err_vld;
  logic signed [15:0] error;
  logic [10:0]        mast_spd;
  logic [10:0]        lft_spd, rht_spd;
  logic               pid_vld;

  int checks = 0;
  int errors = 0;
  int m_integ, m_prev, m_lft, m_rht;

  pid_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .error(error), .err_vld(err_vld),
    .mast_spd(mast_spd), .lft_spd(lft_spd), .rht_spd(rht_spd), .pid_vld(pid_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_clear();
    m_integ = 0; m_prev = 0; m_lft = 0; m_rht = 0;
  endtask

  // One accepted sample: gains 3/7, integrator shift 4, 16-bit integrator that
  // refuses to leave its range, speeds clamped to 11 bits.
  task automatic model_step(input int e, input int mast);
    int es, n, d, pid;
    es = clamp(e, -512, 511);
    n  = m_integ + es;
    if (n >= -32768 && n <= 32767) m_integ = n;
    d      = clamp(es - m_prev, -128, 127);
    m_prev = es;
    pid    = es * 3 + (m_integ >>> 4) + d * 7;
    m_lft  = clamp(mast + pid, 0, 2047);
    m_rht  = clamp(mast - pid, 0, 2047);
  endtask

  // Full transaction: strobe, check pid_vld timing, check speeds, then check hold.
  task automatic sample(input string tag, input logic [15:0] e, input logic [10:0] m);
    int ev;
    ev = $signed(e);
    error = e; mast_spd = m; err_vld = 1'b1;
    @(posedge clk); #1; err_vld = 1'b0;
    model_step(ev, int'(m));
    chk({tag, ".vld_n"}, 32'(pid_vld), 0);
    @(posedge clk); #1;
    chk({tag, ".vld_n1"}, 32'(pid_vld), 0);
    @(posedge clk); #1;
    chk({tag, ".vld_n2"}, 32'(pid_vld), 1);
    chk({tag, ".lft"}, 32'(lft_spd), m_lft);
    chk({tag, ".rht"}, 32'(rht_spd), m_rht);
    @(posedge clk); #1;
    chk({tag, ".vld_drop"}, 32'(pid_vld), 0);
    chk({tag, ".lft_hold"}, 32'(lft_spd), m_lft);
  endtask

  task automatic clear_go(input string tag);
    go = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".clr_lft"}, 32'(lft_spd), 0);
    chk({tag, ".clr_rht"}, 32'(rht_spd), 0);
    go = 1'b1;
    model_clear();
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; err_vld = 1'b0; error = '0; mast_spd = '0;
    model_clear();
    #12;
    chk("rst.lft", 32'(lft_spd), 0);
    chk("rst.rht", 32'(rht_spd), 0);
    chk("rst.vld", 32'(pid_vld), 0);
    rst_n = 1'b1; go = 1'b1;
    @(posedge clk); #1;

    // First sample from fresh state
    sample("t1", 16'd100, 11'd1024);
    chk("t1.lft_abs", 32'(lft_spd), 2030);
    chk("t1.rht_abs", 32'(rht_spd), 18);

    // Positive and negative error saturation
    clear_go("t2");
    sample("t2p", 16'h7FFF, 11'd1024);
    chk("t2.lft_clamp", 32'(lft_spd), 2047);
    chk("t2.rht_clamp", 32'(rht_spd), 0);
    sample("t2n", 16'h8000, 11'd1024);
    chk("t2.err_sat_neg", 32'($signed(dut.err_sat_q)), -512);

    // Integrator overflow hold
    clear_go("t3");
    for (int i = 0; i < 65; i++) sample("t3s", 16'd511, 11'd0);
    chk("t3.integ_hold", 32'($signed(dut.integ_q)), 32704);
    sample("t3z", 16'd0, 11'd0);
    chk("t3.lft_iterm", 32'(lft_spd), 1148);

    // Derivative zero and clamp
    clear_go("t4");
    sample("t4a", 16'd100, 11'd1200);
    sample("t4b", 16'd100, 11'd1200);
    chk("t4.d_zero", 32'($signed(dut.d_sat_q)), 0);
    sample("t4c", -16'sd100, 11'd1200);
    chk("t4.d_clamp", 32'($signed(dut.d_sat_q)), -128);
    chk("t4.lft_abs", 32'(lft_spd), 10);

    // go dropped during CALC
    sample("t5pre", 16'd40, 11'd1024);
    error = 16'd200; err_vld = 1'b1;
    @(posedge clk); #1; err_vld = 1'b0; go = 1'b0;
    @(posedge clk); #1;
    chk("t5.lft0", 32'(lft_spd), 0);
    chk("t5.rht0", 32'(rht_spd), 0);
    chk("t5.vld0", 32'(pid_vld), 0);
    chk("t5.integ0", 32'($signed(dut.integ_q)), 0);
    chk("t5.prev0", 32'($signed(dut.prev_err_q)), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5.no_vld", 32'(pid_vld), 0);
    end
    go = 1'b1; model_clear();

    // err_vld held through CALC/OUT with changing data is ignored
    error = 16'd50; mast_spd = 11'd1024; err_vld = 1'b1;
    @(posedge clk); #1;
    model_step(50, 1024);
    chk("t5i.vld_n", 32'(pid_vld), 0);
    error = 16'd300;
    @(posedge clk); #1;
    chk("t5i.vld_n1", 32'(pid_vld), 0);
    error = -16'sd300;
    @(posedge clk); #1; err_vld = 1'b0;
    chk("t5i.vld_n2", 32'(pid_vld), 1);
    chk("t5i.lft", 32'(lft_spd), m_lft);
    chk("t5i.rht", 32'(rht_spd), m_rht);
    chk("t5i.prev", 32'($signed(dut.prev_err_q)), 50);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5i.single_vld", 32'(pid_vld), 0);
    end

    // Asynchronous reset while in OUT
    error = -16'sd37; mast_spd = 11'd700; err_vld = 1'b1;
    @(posedge clk); #1; err_vld = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6.lft0", 32'(lft_spd), 0);
    chk("t6.rht0", 32'(rht_spd), 0);
    chk("t6.vld0", 32'(pid_vld), 0);
    #2 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6.no_vld", 32'(pid_vld), 0);
    end
    chk("t6.integ0", 32'($signed(dut.integ_q)), 0);

    // Randomized samples with idle gaps and occasional go drops
    for (int i = 0; i < 40; i++) begin
      logic [15:0] e;
      int gap;
      if ($urandom_range(0, 7) == 0) clear_go("rnd");
      if ($urandom_range(0, 1) == 0) e = 16'($urandom);
      else                           e = 16'($signed($urandom_range(0, 1400)) - 700);
      sample("rnd", e, 11'($urandom_range(0, 2047)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("rnd.gap_lft", 32'(lft_spd), m_lft);
        chk("rnd.gap_vld", 32'(pid_vld), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
